// File: rtl/hazard_stall_controller_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard stall controller (slave).
interface hazard_stall_controller_if #(
  parameter int unsigned NB_REG_ADDR = 5,
  parameter int unsigned NB_CNT      = 16
) ();
  logic                   i_valid;
  logic [NB_REG_ADDR-1:0] i_rs_id;
  logic [NB_REG_ADDR-1:0] i_rt_id;
  logic                   i_use_rs_id;
  logic                   i_use_rt_id;
  logic                   i_jump_rs_id;
  logic                   i_halt_id;
  logic                   i_mem_read_ex;
  logic                   i_we_ex;
  logic [NB_REG_ADDR-1:0] i_rd_ex;
  logic                   i_flush_ex;
  logic                   i_resume;
  logic                   o_stall_pc;
  logic                   o_stall_ifid;
  logic                   o_bubble_idex;
  logic                   o_flush_ifid;
  logic                   o_halted;
  logic [NB_CNT-1:0]      o_stall_cycles;

  modport master (
    output i_valid, i_rs_id, i_rt_id, i_use_rs_id, i_use_rt_id, i_jump_rs_id, i_halt_id,
    output i_mem_read_ex, i_we_ex, i_rd_ex, i_flush_ex, i_resume,
    input  o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid, o_halted, o_stall_cycles
  );

  modport slave (
    input  i_valid, i_rs_id, i_rt_id, i_use_rs_id, i_use_rt_id, i_jump_rs_id, i_halt_id,
    input  i_mem_read_ex, i_we_ex, i_rd_ex, i_flush_ex, i_resume,
    output o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid, o_halted, o_stall_cycles
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / JR hazard stall sequencer with HALT drain and a saturating stall-cycle counter.
module hazard_stall_controller #(
  parameter int unsigned NB_REG_ADDR = 5,
  parameter int unsigned NB_CNT      = 16,
  parameter int unsigned DRAIN_CYC   = 3
) (
  input logic                      i_clock,
  input logic                      i_reset,
  hazard_stall_controller_if.slave bus_io
);

  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {StRun, StJrStall, StDrain, StHalted} state_e;

  state_e              state_q, state_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic [NB_CNT-1:0]   stall_cnt_q, stall_cnt_d;

  logic [NB_REG_ADDR-1:0] rd_ex;
  logic rs_match, rt_match, hz_ex;
  logic stall_pc, stall_ifid, bubble_idex, flush_ifid;

  assign rd_ex    = bus_io.i_rd_ex;
  assign rs_match = (bus_io.i_rs_id == rd_ex);
  assign rt_match = (bus_io.i_rt_id == rd_ex);
  assign hz_ex    = bus_io.i_mem_read_ex & bus_io.i_we_ex & (rd_ex != '0) &
                    (((bus_io.i_use_rs_id | bus_io.i_jump_rs_id) & rs_match) |
                     (bus_io.i_use_rt_id & rt_match));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (bus_io.i_flush_ex) begin
          flush_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end else if (hz_ex) begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          bubble_idex = 1'b1;
          // JR needs rs in ID, so the load must reach WB before it can proceed
          if (bus_io.i_jump_rs_id && rs_match) state_d = StJrStall;
        end else if (bus_io.i_halt_id) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          state_d    = StDrain;
          drain_d    = DrainInit;
        end
      end
      StJrStall: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
        state_d     = StRun;
      end
      StDrain: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
        if (drain_q == '0) state_d = StHalted;
        else               drain_d = drain_q - 1'b1;
      end
      StHalted: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
        if (bus_io.i_resume) state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall_pc && (state_q != StHalted) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StRun;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else if (bus_io.i_valid) begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Stall/flush controls are forced low while reset is asserted, regardless of inputs
  assign bus_io.o_stall_pc     = i_reset & stall_pc;
  assign bus_io.o_stall_ifid   = i_reset & stall_ifid;
  assign bus_io.o_bubble_idex  = i_reset & bubble_idex;
  assign bus_io.o_flush_ifid   = i_reset & flush_ifid;
  assign bus_io.o_halted       = (state_q == StHalted);
  assign bus_io.o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller; a second 4-bit-counter instance shares the stimulus.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic rst_n;

  hazard_stall_controller_if #(.NB_REG_ADDR(5), .NB_CNT(16)) bus16 ();
  hazard_stall_controller_if #(.NB_REG_ADDR(5), .NB_CNT(4))  bus4 ();

  assign bus4.i_valid       = bus16.i_valid;
  assign bus4.i_rs_id       = bus16.i_rs_id;
  assign bus4.i_rt_id       = bus16.i_rt_id;
  assign bus4.i_use_rs_id   = bus16.i_use_rs_id;
  assign bus4.i_use_rt_id   = bus16.i_use_rt_id;
  assign bus4.i_jump_rs_id  = bus16.i_jump_rs_id;
  assign bus4.i_halt_id     = bus16.i_halt_id;
  assign bus4.i_mem_read_ex = bus16.i_mem_read_ex;
  assign bus4.i_we_ex       = bus16.i_we_ex;
  assign bus4.i_rd_ex       = bus16.i_rd_ex;
  assign bus4.i_flush_ex    = bus16.i_flush_ex;
  assign bus4.i_resume      = bus16.i_resume;

  hazard_stall_controller #(.NB_REG_ADDR(5), .NB_CNT(16), .DRAIN_CYC(3)) u_dut16 (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus_io  (bus16.slave)
  );

  hazard_stall_controller #(.NB_REG_ADDR(5), .NB_CNT(4), .DRAIN_CYC(3)) u_dut4 (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus_io  (bus4.slave)
  );

  always #5 clk = ~clk;

  // flags = {stall_pc, stall_ifid, bubble_idex, flush_ifid, halted}
  typedef struct {
    string       tag;
    logic [4:0]  flags;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned exp_cnt;
  int          n_checks;
  int          n_pass;

  task automatic idle();
    bus16.i_valid       = 1'b1;
    bus16.i_rs_id       = '0;
    bus16.i_rt_id       = '0;
    bus16.i_use_rs_id   = 1'b0;
    bus16.i_use_rt_id   = 1'b0;
    bus16.i_jump_rs_id  = 1'b0;
    bus16.i_halt_id     = 1'b0;
    bus16.i_mem_read_ex = 1'b0;
    bus16.i_we_ex       = 1'b0;
    bus16.i_rd_ex       = '0;
    bus16.i_flush_ex    = 1'b0;
    bus16.i_resume      = 1'b0;
  endtask

  task automatic load_ex(input logic [4:0] rd);
    bus16.i_mem_read_ex = 1'b1;
    bus16.i_we_ex       = 1'b1;
    bus16.i_rd_ex       = rd;
  endtask

  // Push expectation, sample mid-cycle, compare, then advance one clock.
  task automatic step(input string tag, input logic [4:0] flags);
    exp_t       e;
    exp_t       got;
    logic [4:0] obs;
    logic [3:0] exp4;
    e.tag   = tag;
    e.flags = flags;
    e.cnt   = exp_cnt;
    sb.push_back(e);
    #1;
    got  = sb.pop_front();
    obs  = {bus16.o_stall_pc, bus16.o_stall_ifid, bus16.o_bubble_idex,
            bus16.o_flush_ifid, bus16.o_halted};
    exp4 = (got.cnt > 15) ? 4'hF : 4'(got.cnt);
    n_checks++;
    assert (obs === got.flags) n_pass++;
    else $error("FAIL %s flags: got %b want %b", got.tag, obs, got.flags);
    n_checks++;
    assert (bus16.o_stall_cycles === 16'(got.cnt)) n_pass++;
    else $error("FAIL %s cnt16: got %0d want %0d", got.tag, bus16.o_stall_cycles, got.cnt);
    n_checks++;
    assert (bus4.o_stall_cycles === exp4) n_pass++;
    else $error("FAIL %s cnt4: got %0d want %0d", got.tag, bus4.o_stall_cycles, exp4);
    @(posedge clk);
    if (bus16.i_valid && rst_n && flags[4] && !flags[0]) exp_cnt++;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = 0;

    // Reset with a live hazard on the inputs: all controls must stay low
    rst_n = 1'b0;
    idle();
    load_ex(5'd3);
    bus16.i_rs_id = 5'd3; bus16.i_use_rs_id = 1'b1;
    step("reset", 5'b00000);
    rst_n = 1'b1;
    idle(); step("idle0", 5'b00000);

    idle(); load_ex(5'd3); bus16.i_rs_id = 5'd3; bus16.i_use_rs_id = 1'b1;
    step("lw_use_rs", 5'b11100);
    idle(); step("after_lw", 5'b00000);

    idle(); load_ex(5'd0); bus16.i_rs_id = 5'd0; bus16.i_use_rs_id = 1'b1;
    step("lw_r0", 5'b00000);

    idle(); load_ex(5'd3); bus16.i_rs_id = 5'd5; bus16.i_use_rs_id = 1'b1;
    bus16.i_rt_id = 5'd3;
    step("rt_unused", 5'b00000);

    idle(); load_ex(5'd3); bus16.i_rt_id = 5'd3; bus16.i_use_rt_id = 1'b1;
    step("lw_use_rt", 5'b11100);

    idle(); load_ex(5'd3); bus16.i_rs_id = 5'd3; bus16.i_use_rs_id = 1'b1;
    bus16.i_flush_ex = 1'b1;
    step("hz_flush", 5'b00110);
    idle(); step("after_flush", 5'b00000);

    idle(); load_ex(5'd3); bus16.i_rs_id = 5'd3; bus16.i_jump_rs_id = 1'b1;
    step("jr_hz", 5'b11100);
    for (int k = 0; k < 5; k++) begin
      idle(); bus16.i_valid = 1'b0;
      step("jr_frozen", 5'b11100);
    end
    idle(); step("jr_stall", 5'b11100);
    idle(); step("after_jr", 5'b00000);

    idle(); bus16.i_we_ex = 1'b1; bus16.i_rd_ex = 5'd3;
    bus16.i_rs_id = 5'd3; bus16.i_use_rs_id = 1'b1;
    step("alu_no_hz", 5'b00000);

    idle(); bus16.i_halt_id = 1'b1;
    step("halt", 5'b11000);
    for (int k = 0; k < 3; k++) begin
      idle(); load_ex(5'd3); bus16.i_rs_id = 5'd3; bus16.i_use_rs_id = 1'b1;
      bus16.i_flush_ex = 1'b1; bus16.i_halt_id = 1'b1;
      step("drain", 5'b11100);
    end
    idle(); step("halted", 5'b11101);
    idle(); step("halted_hold", 5'b11101);
    idle(); bus16.i_resume = 1'b1;
    step("resume", 5'b11101);
    idle(); step("after_resume", 5'b00000);

    for (int k = 0; k < 12; k++) begin
      idle(); load_ex(5'd7); bus16.i_rs_id = 5'd7; bus16.i_use_rs_id = 1'b1;
      step("sat_stall", 5'b11100);
    end
    idle(); step("sat_hold", 5'b00000);

    idle(); bus16.i_halt_id = 1'b1;
    step("halt2", 5'b11000);
    idle(); step("drain2", 5'b11100);

    // Reset mid-drain, asserted away from any clock edge
    idle(); load_ex(5'd3); bus16.i_rs_id = 5'd3; bus16.i_use_rs_id = 1'b1;
    #2;
    rst_n   = 1'b0;
    exp_cnt = 0;
    step("rst_drain", 5'b00000);
    rst_n = 1'b1;
    idle(); step("post_rst", 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
